// File: rtl/fpga_stream_sink_pkg.sv
// -----------------------------------------------------------------------------
// fpga_stream_sink_pkg
// Shared constants for the stream sink: Avalon-MM register word addresses and
// bit positions inside the STAT and CTRL registers.
// No ports (package).
// -----------------------------------------------------------------------------
package fpga_stream_sink_pkg;

  // Register word addresses on the Avalon-MM slave
  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_STAT = 2'd1;
  localparam logic [1:0] ADDR_CNT  = 2'd2;
  localparam logic [1:0] ADDR_CTRL = 2'd3;

  // STAT register bit positions
  localparam int STAT_EMPTY      = 0;
  localparam int STAT_FULL       = 1;
  localparam int STAT_FRAME_DONE = 2;
  localparam int STAT_UNDERFLOW  = 3;
  localparam int STAT_ENABLE     = 4;
  localparam int STAT_LAST_LSB   = 5;
  localparam int STAT_LEVEL_LSB  = 16;

  // CTRL register bit positions
  localparam int CTRL_ENABLE = 0;
  localparam int CTRL_CLEAR  = 1;

  // Place a byte into its little-endian lane of a 32-bit word
  function automatic logic [31:0] lane_insert(input logic [7:0] data,
                                              input logic [1:0] lane);
    return {24'd0, data} << {lane, 3'b000};
  endfunction

endpackage

// File: rtl/fpga_stream_sink_if.sv
// -----------------------------------------------------------------------------
// fpga_stream_sink_if
// Bundles the 8-bit AXI4-Stream input and the Avalon-MM slave bus of the
// stream sink.
//   slave  : seen by the sink (accepts stream, answers register accesses)
//   master : seen by whoever drives the stream and the HPS bus
// Signals:
//   axis4_s_tdata/tvalid/tlast -> sink, axis4_s_tready <- sink
//   avs_address/chipselect/read/write_n/writedata -> sink, avs_readdata <- sink
// -----------------------------------------------------------------------------
interface fpga_stream_sink_if;

  logic [7:0]  axis4_s_tdata;
  logic        axis4_s_tvalid;
  logic        axis4_s_tlast;
  logic        axis4_s_tready;

  logic [1:0]  avs_address;
  logic        avs_chipselect;
  logic        avs_read;
  logic        avs_write_n;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;

  modport slave (
    input  axis4_s_tdata, axis4_s_tvalid, axis4_s_tlast,
    output axis4_s_tready,
    input  avs_address, avs_chipselect, avs_read, avs_write_n, avs_writedata,
    output avs_readdata
  );

  modport master (
    output axis4_s_tdata, axis4_s_tvalid, axis4_s_tlast,
    input  axis4_s_tready,
    output avs_address, avs_chipselect, avs_read, avs_write_n, avs_writedata,
    input  avs_readdata
  );

endinterface

// File: rtl/fpga_stream_sink_fifo.sv
// -----------------------------------------------------------------------------
// fpga_stream_sink_fifo
// Synchronous show-ahead FIFO, 32 bits wide, 2^FIFO_AW words deep. The head
// word is always present on rdata; pop just advances past it.
// Ports:
//   clk, reset : clock, asynchronous active-high reset (pointers only)
//   clear      : synchronous flush, wins over push/pop
//   push/wdata : write a word (ignored when full)
//   pop        : discard the head word (ignored when empty)
//   rdata      : head word (undefined content when empty)
//   empty/full : status flags
//   level      : number of stored words, FIFO_AW+1 bits
// -----------------------------------------------------------------------------
module fpga_stream_sink_fifo #(
  parameter int FIFO_AW = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               push,
  input  logic [31:0]        wdata,
  input  logic               pop,
  output logic [31:0]        rdata,
  output logic               empty,
  output logic               full,
  output logic [FIFO_AW:0]   level
);

  localparam int DEPTH = 1 << FIFO_AW;

  logic [31:0]      mem [DEPTH];
  logic [FIFO_AW:0] wptr;
  logic [FIFO_AW:0] rptr;
  logic             do_push;
  logic             do_pop;

  // Pointers carry one extra wrap bit: equal means empty, differing only in
  // the wrap bit means full.
  assign empty   = (wptr == rptr);
  assign full    = ((wptr ^ rptr) == {1'b1, {FIFO_AW{1'b0}}});
  assign level   = wptr - rptr;
  assign do_push = push & ~full & ~clear;
  assign do_pop  = pop & ~empty & ~clear;
  assign rdata   = mem[rptr[FIFO_AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else if (clear) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  // Storage has no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[FIFO_AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/fpga_stream_sink.sv
// -----------------------------------------------------------------------------
// fpga_stream_sink
// Consumes an 8-bit AXI4-Stream, packs bytes little-endian into 32-bit words,
// buffers them in a show-ahead FIFO and exposes them to the HPS over an
// Avalon-MM slave together with frame status, byte count and byte checksum.
// A partial word is flushed zero-padded on tlast.
// Ports:
//   clk   : system clock
//   reset : asynchronous active-high reset
//   bus   : stream input + Avalon-MM slave (fpga_stream_sink_if.slave)
// Registers: 0 DATA (R, pops), 1 STAT (R), 2 CNT (R), 3 CTRL (R/W)
// -----------------------------------------------------------------------------
module fpga_stream_sink
  import fpga_stream_sink_pkg::*;
#(
  parameter int FIFO_AW = 4
) (
  input  logic                clk,
  input  logic                reset,
  fpga_stream_sink_if.slave   bus
);

  logic              enable;
  logic [1:0]        lane;
  logic [31:0]       hold_word;
  logic              frame_done;
  logic              underflow;
  logic [2:0]        last_bytes;
  logic [15:0]       byte_count;
  logic [15:0]       byte_sum;

  logic              wr_en;
  logic              ctrl_wr;
  logic              clear_wr;
  logic              pop_req;
  logic              accept;
  logic              push;
  logic [31:0]       word_next;

  logic [31:0]       fifo_rdata;
  logic              fifo_empty;
  logic              fifo_full;
  logic [FIFO_AW:0]  fifo_level;

  logic [31:0]       stat_word;
  logic              unused_wdata;

  assign wr_en    = bus.avs_chipselect & ~bus.avs_write_n;
  assign ctrl_wr  = wr_en & (bus.avs_address == ADDR_CTRL);
  assign clear_wr = ctrl_wr & bus.avs_writedata[CTRL_CLEAR];
  assign pop_req  = bus.avs_chipselect & bus.avs_read & (bus.avs_address == ADDR_DATA);

  // A pending clear blocks the stream so no beat is lost to the flush.
  assign bus.axis4_s_tready = enable & ~fifo_full & ~clear_wr;
  assign accept    = bus.axis4_s_tvalid & bus.axis4_s_tready;
  assign word_next = hold_word | lane_insert(bus.axis4_s_tdata, lane);
  assign push      = accept & ((lane == 2'd3) | bus.axis4_s_tlast);

  assign unused_wdata = ^bus.avs_writedata[31:2];

  fpga_stream_sink_fifo #(
    .FIFO_AW (FIFO_AW)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clear (clear_wr),
    .push  (push),
    .wdata (word_next),
    .pop   (pop_req),
    .rdata (fifo_rdata),
    .empty (fifo_empty),
    .full  (fifo_full),
    .level (fifo_level)
  );

  // Packer: bytes accumulate in hold_word; the assembled word (current byte
  // included) is pushed straight from word_next, so hold_word restarts at 0.
  // While disabled no beat is accepted and the partial word simply waits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lane      <= 2'd0;
      hold_word <= '0;
    end else if (clear_wr) begin
      lane      <= 2'd0;
      hold_word <= '0;
    end else if (accept) begin
      if (push) begin
        lane      <= 2'd0;
        hold_word <= '0;
      end else begin
        lane      <= lane + 2'd1;
        hold_word <= word_next;
      end
    end
  end

  // Control, sticky status and frame counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enable     <= 1'b0;
      frame_done <= 1'b0;
      underflow  <= 1'b0;
      last_bytes <= 3'd0;
      byte_count <= '0;
      byte_sum   <= '0;
    end else begin
      if (ctrl_wr) enable <= bus.avs_writedata[CTRL_ENABLE];
      if (clear_wr) begin
        frame_done <= 1'b0;
        underflow  <= 1'b0;
        last_bytes <= 3'd0;
        byte_count <= '0;
        byte_sum   <= '0;
      end else begin
        if (accept) begin
          byte_count <= byte_count + 16'd1;
          byte_sum   <= byte_sum + {8'd0, bus.axis4_s_tdata};
          if (bus.axis4_s_tlast) begin
            frame_done <= 1'b1;
            last_bytes <= {1'b0, lane} + 3'd1;
          end
        end
        if (pop_req && fifo_empty) underflow <= 1'b1;
      end
    end
  end

  always_comb begin
    stat_word                                 = '0;
    stat_word[STAT_EMPTY]                     = fifo_empty;
    stat_word[STAT_FULL]                      = fifo_full;
    stat_word[STAT_FRAME_DONE]                = frame_done;
    stat_word[STAT_UNDERFLOW]                 = underflow;
    stat_word[STAT_ENABLE]                    = enable;
    stat_word[STAT_LAST_LSB +: 3]             = last_bytes;
    stat_word[STAT_LEVEL_LSB +: 16]           = 16'(fifo_level);
  end

  // Zero-wait-state read mux; DATA reads 0 when nothing is buffered.
  always_comb begin
    bus.avs_readdata = '0;
    case (bus.avs_address)
      ADDR_DATA: bus.avs_readdata = fifo_empty ? 32'd0 : fifo_rdata;
      ADDR_STAT: bus.avs_readdata = stat_word;
      ADDR_CNT:  bus.avs_readdata = {byte_sum, byte_count};
      ADDR_CTRL: bus.avs_readdata = {31'd0, enable};
      default:   bus.avs_readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_fpga_stream_sink.sv
// -----------------------------------------------------------------------------
// tb_fpga_stream_sink
// Directed self-checking bench for fpga_stream_sink (FIFO_AW = 4).
// -----------------------------------------------------------------------------
module tb_fpga_stream_sink;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  fpga_stream_sink_if bus_if ();

  fpga_stream_sink #(
    .FIFO_AW (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // All tasks start and end 1 time unit after a rising edge.
  task automatic avs_rd(input logic [1:0] addr, output logic [31:0] data);
    bus_if.avs_address    = addr;
    bus_if.avs_chipselect = 1'b1;
    bus_if.avs_read       = 1'b1;
    #1;
    data = bus_if.avs_readdata;
    @(posedge clk);
    #1;
    bus_if.avs_chipselect = 1'b0;
    bus_if.avs_read       = 1'b0;
    bus_if.avs_address    = 2'd1;
  endtask

  task automatic avs_wr(input logic [1:0] addr, input logic [31:0] data);
    bus_if.avs_address    = addr;
    bus_if.avs_chipselect = 1'b1;
    bus_if.avs_write_n    = 1'b0;
    bus_if.avs_writedata  = data;
    @(posedge clk);
    #1;
    bus_if.avs_chipselect = 1'b0;
    bus_if.avs_write_n    = 1'b1;
    bus_if.avs_writedata  = '0;
    bus_if.avs_address    = 2'd1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    bit ok;
    ok = 1'b0;
    bus_if.axis4_s_tdata  = b;
    bus_if.axis4_s_tlast  = last;
    bus_if.axis4_s_tvalid = 1'b1;
    for (int w = 0; w < 20 && !ok; w++) begin
      #1;
      if (bus_if.axis4_s_tready === 1'b1) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    bus_if.axis4_s_tvalid = 1'b0;
    bus_if.axis4_s_tlast  = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL send_byte_timeout: byte %h not accepted, tready=%b required 1", b, bus_if.axis4_s_tready);
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    checks++;
    if (bus_if.axis4_s_tready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_tready: got %b required 0", bus_if.axis4_s_tready);
    end
    avs_rd(2'd1, d);
    checks++;
    if (d !== 32'h0000_0001) begin
      errors++;
      $display("[TB] FAIL reset_stat: got %h required 00000001", d);
    end
    avs_rd(2'd2, d);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_cnt: got %h required 00000000", d);
    end
  endtask

  task automatic test_full_words();
    logic [31:0] d;
    avs_wr(2'd3, 32'h1);
    for (int i = 1; i <= 8; i++) send_byte(8'(i), i == 8);
    avs_rd(2'd1, d);
    checks++;
    if (d !== 32'h0002_0094) begin
      errors++;
      $display("[TB] FAIL frame8_stat: got %h required 00020094", d);
    end
    avs_rd(2'd2, d);
    checks++;
    if (d !== 32'h0024_0008) begin
      errors++;
      $display("[TB] FAIL frame8_cnt: got %h required 00240008", d);
    end
    avs_rd(2'd0, d);
    checks++;
    if (d !== 32'h0403_0201) begin
      errors++;
      $display("[TB] FAIL frame8_word0: got %h required 04030201", d);
    end
    avs_rd(2'd0, d);
    checks++;
    if (d !== 32'h0807_0605) begin
      errors++;
      $display("[TB] FAIL frame8_word1: got %h required 08070605", d);
    end
    avs_rd(2'd1, d);
    checks++;
    if (d !== 32'h0000_0095) begin
      errors++;
      $display("[TB] FAIL frame8_stat_after: got %h required 00000095", d);
    end
  endtask

  task automatic test_partial_word();
    logic [31:0] d;
    for (int i = 0; i < 5; i++) send_byte(8'(8'hA0 + i), i == 4);
    avs_rd(2'd1, d);
    checks++;
    if (d !== 32'h0002_0034) begin
      errors++;
      $display("[TB] FAIL partial_stat: got %h required 00020034", d);
    end
    avs_rd(2'd2, d);
    checks++;
    if (d !== 32'h034E_000D) begin
      errors++;
      $display("[TB] FAIL partial_cnt: got %h required 034E000D", d);
    end
    avs_rd(2'd0, d);
    checks++;
    if (d !== 32'hA3A2_A1A0) begin
      errors++;
      $display("[TB] FAIL partial_word0: got %h required A3A2A1A0", d);
    end
    avs_rd(2'd0, d);
    checks++;
    if (d !== 32'h0000_00A4) begin
      errors++;
      $display("[TB] FAIL partial_word1: got %h required 000000A4", d);
    end
    avs_rd(2'd1, d);
    checks++;
    if (d[31:16] !== 16'd0) begin
      errors++;
      $display("[TB] FAIL partial_level_after: got %0d required 0", d[31:16]);
    end
  endtask

  task automatic test_fifo_full();
    logic [31:0] d;
    int accepted;
    logic [7:0] next_b;
    avs_wr(2'd3, 32'h3);
    accepted = 0;
    next_b   = 8'd0;
    for (int c = 0; c < 80; c++) begin
      bus_if.axis4_s_tdata  = next_b;
      bus_if.axis4_s_tvalid = 1'b1;
      #1;
      if (bus_if.axis4_s_tready === 1'b1) begin
        accepted++;
        next_b++;
      end
      @(posedge clk);
      #1;
    end
    bus_if.axis4_s_tvalid = 1'b0;
    checks++;
    if (accepted != 64) begin
      errors++;
      $display("[TB] FAIL full_accepted: got %0d required 64", accepted);
    end
    checks++;
    if (bus_if.axis4_s_tready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL full_tready: got %b required 0", bus_if.axis4_s_tready);
    end
    avs_rd(2'd1, d);
    checks++;
    if (d !== 32'h0010_0012) begin
      errors++;
      $display("[TB] FAIL full_stat: got %h required 00100012", d);
    end
    avs_rd(2'd0, d);
    checks++;
    if (d !== 32'h0302_0100) begin
      errors++;
      $display("[TB] FAIL full_head: got %h required 03020100", d);
    end
    checks++;
    if (bus_if.axis4_s_tready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL full_tready_after_pop: got %b required 1", bus_if.axis4_s_tready);
    end
    accepted = 0;
    for (int c = 0; c < 10; c++) begin
      bus_if.axis4_s_tdata  = next_b;
      bus_if.axis4_s_tvalid = 1'b1;
      #1;
      if (bus_if.axis4_s_tready === 1'b1) begin
        accepted++;
        next_b++;
      end
      @(posedge clk);
      #1;
    end
    bus_if.axis4_s_tvalid = 1'b0;
    checks++;
    if (accepted != 4) begin
      errors++;
      $display("[TB] FAIL refill_accepted: got %0d required 4", accepted);
    end
    avs_rd(2'd1, d);
    checks++;
    if (d !== 32'h0010_0012) begin
      errors++;
      $display("[TB] FAIL refill_stat: got %h required 00100012", d);
    end
    avs_rd(2'd2, d);
    checks++;
    if (d !== 32'h08E6_0044) begin
      errors++;
      $display("[TB] FAIL refill_cnt: got %h required 08E60044", d);
    end
  endtask

  task automatic test_underflow();
    logic [31:0] d;
    avs_wr(2'd3, 32'h2);
    avs_rd(2'd0, d);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("[TB] FAIL underflow_data: got %h required 00000000", d);
    end
    avs_rd(2'd1, d);
    checks++;
    if (d !== 32'h0000_0009) begin
      errors++;
      $display("[TB] FAIL underflow_stat: got %h required 00000009", d);
    end
    avs_wr(2'd3, 32'h3);
    avs_rd(2'd1, d);
    checks++;
    if (d !== 32'h0000_0011) begin
      errors++;
      $display("[TB] FAIL underflow_cleared_stat: got %h required 00000011", d);
    end
  endtask

  task automatic test_clear_mid_word();
    logic [31:0] d;
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    avs_wr(2'd3, 32'h3);
    for (int i = 0; i < 4; i++) send_byte(8'(8'h33 + i), 1'b0);
    avs_rd(2'd2, d);
    checks++;
    if (d !== 32'h00D2_0004) begin
      errors++;
      $display("[TB] FAIL clear_cnt: got %h required 00D20004", d);
    end
    avs_rd(2'd0, d);
    checks++;
    if (d !== 32'h3635_3433) begin
      errors++;
      $display("[TB] FAIL clear_word: got %h required 36353433", d);
    end
    avs_rd(2'd1, d);
    checks++;
    if (d !== 32'h0000_0011) begin
      errors++;
      $display("[TB] FAIL clear_stat: got %h required 00000011", d);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] d;
    send_byte(8'h55, 1'b0);
    bus_if.axis4_s_tdata  = 8'h66;
    bus_if.axis4_s_tvalid = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (bus_if.axis4_s_tready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_mid_tready: got %b required 0", bus_if.axis4_s_tready);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus_if.axis4_s_tvalid = 1'b0;
    @(posedge clk);
    #1;
    avs_rd(2'd1, d);
    checks++;
    if (d !== 32'h0000_0001) begin
      errors++;
      $display("[TB] FAIL reset_mid_stat: got %h required 00000001", d);
    end
    avs_rd(2'd2, d);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_mid_cnt: got %h required 00000000", d);
    end
    avs_rd(2'd3, d);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_mid_ctrl: got %h required 00000000", d);
    end
    checks++;
    if (bus_if.axis4_s_tready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_mid_tready_after: got %b required 0", bus_if.axis4_s_tready);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    bus_if.axis4_s_tdata  = '0;
    bus_if.axis4_s_tvalid = 1'b0;
    bus_if.axis4_s_tlast  = 1'b0;
    bus_if.avs_address    = 2'd1;
    bus_if.avs_chipselect = 1'b0;
    bus_if.avs_read       = 1'b0;
    bus_if.avs_write_n    = 1'b1;
    bus_if.avs_writedata  = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_full_words();
    test_partial_word();
    test_fifo_full();
    test_underflow();
    test_clear_mid_word();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
